// File: rtl/mel_pkg.sv
// Shared constants and FSM encoding for the mel frame serializer.
package mel_pkg;

  localparam int unsigned N_BANDS = 64;
  localparam int unsigned BAND_W  = 6;
  localparam int unsigned GRP_W   = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/mel_frame_buf.sv
// Two-slot ping-pong frame store: write port, current-slot and other-slot read selects.
module mel_frame_buf
  import mel_pkg::*;
#(
  parameter int unsigned I_BW = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [I_BW*N_BANDS-1:0]   wr_data,
  input  logic [GRP_W-1:0]          wr_grp,
  input  logic                      rd_pop,
  output logic [I_BW*N_BANDS-1:0]   rd_data_c,
  output logic [I_BW*N_BANDS-1:0]   nx_data_c,
  output logic [GRP_W-1:0]          nx_grp_c,
  output logic [1:0]                occ
);

  localparam int unsigned FW = I_BW * N_BANDS;

  logic [FW-1:0]    slot_data [2];
  logic [GRP_W-1:0] slot_grp  [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Slot payload; contents only matter while occupancy marks them valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot_data[wr_ptr] <= wr_data;
      slot_grp[wr_ptr]  <= wr_grp;
    end
  end

  // Pointers and occupancy; a simultaneous write and pop keep occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr_en)  wr_ptr <= ~wr_ptr;
      if (rd_pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(wr_en) - 2'(rd_pop);
    end
  end

  assign rd_data_c = slot_data[rd_ptr];
  assign nx_data_c = slot_data[~rd_ptr];
  assign nx_grp_c  = slot_grp[~rd_ptr];

endmodule

// File: rtl/mel_frame_serializer.sv
// Serializes packed 64-band mel frames into one band per accepted cycle.
// Optional build macro MEL_SER_CLAMP_NEG_EN: negative band values are output as 0.
module mel_frame_serializer #(
  parameter int unsigned I_BW    = 14,
  parameter int unsigned N_BANDS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         di_en,
  input  logic [I_BW*N_BANDS-1:0]      data_i,
  input  logic [mel_pkg::GRP_W-1:0]    in_group_num,
  input  logic                         o_ready,
  output logic                         do_en,
  output logic [I_BW-1:0]              data_o,
  output logic [mel_pkg::BAND_W-1:0]   band_idx,
  output logic                         is_first_out,
  output logic                         is_last_out,
  output logic [mel_pkg::GRP_W-1:0]    out_group_num,
  output logic                         overflow
);

  import mel_pkg::*;

  localparam int unsigned FW = I_BW * N_BANDS;
  localparam logic [BAND_W-1:0] LAST = BAND_W'(N_BANDS - 1);

  ser_state_e        state, state_nx;
  logic              do_en_nx;
  logic [I_BW-1:0]   data_nx;
  logic [BAND_W-1:0] idx_nx;
  logic              first_nx, last_nx;
  logic [GRP_W-1:0]  grp_nx;

  logic              xfer_c, last_xfer_c, accept_c, drop_c;
  logic [1:0]        occ;
  logic [FW-1:0]     rd_data_c, nx_data_c, start_data_c;
  logic [GRP_W-1:0]  nx_grp_c, start_grp_c;

  // Band b sits at bits [(63-b)*I_BW +: I_BW]; ~idx equals 63-idx for a 6-bit index.
  function automatic logic [I_BW-1:0] band_of(input logic [FW-1:0] frame,
                                              input logic [BAND_W-1:0] idx);
    logic [BAND_W-1:0] rev;
    logic [I_BW-1:0]   v;
    rev = ~idx;
    v   = I_BW'(frame >> (32'(rev) * I_BW));
`ifdef MEL_SER_CLAMP_NEG_EN
    // Negative values only come from upstream accumulator wrap.
    if (v[I_BW-1]) v = '0;
`endif
    return v;
  endfunction

  assign xfer_c      = do_en && o_ready;
  assign last_xfer_c = xfer_c && (band_idx == LAST);
  // A full buffer still accepts when band 63 leaves on the same edge.
  assign accept_c    = di_en && ((occ != 2'd2) || last_xfer_c);
  assign drop_c      = di_en && !accept_c;

  // Next frame comes from the other stored slot if one is waiting, else straight from the input.
  assign start_data_c = (occ == 2'd2) ? nx_data_c : data_i;
  assign start_grp_c  = (occ == 2'd2) ? nx_grp_c  : in_group_num;

  mel_frame_buf #(
    .I_BW (I_BW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (accept_c),
    .wr_data   (data_i),
    .wr_grp    (in_group_num),
    .rd_pop    (last_xfer_c),
    .rd_data_c (rd_data_c),
    .nx_data_c (nx_data_c),
    .nx_grp_c  (nx_grp_c),
    .occ       (occ)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      do_en         <= 1'b0;
      data_o        <= '0;
      band_idx      <= '0;
      is_first_out  <= 1'b0;
      is_last_out   <= 1'b0;
      out_group_num <= '0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_nx;
      do_en         <= do_en_nx;
      data_o        <= data_nx;
      band_idx      <= idx_nx;
      is_first_out  <= first_nx;
      is_last_out   <= last_nx;
      out_group_num <= grp_nx;
      overflow      <= overflow | drop_c;
    end
  end

  // Next-state and next-output selection; outputs hold unless a band transfers or a frame starts.
  always_comb begin
    state_nx = state;
    do_en_nx = do_en;
    data_nx  = data_o;
    idx_nx   = band_idx;
    first_nx = is_first_out;
    last_nx  = is_last_out;
    grp_nx   = out_group_num;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_nx = SEND;
          do_en_nx = 1'b1;
          idx_nx   = '0;
          data_nx  = band_of(start_data_c, '0);
          first_nx = 1'b1;
          last_nx  = 1'b0;
          grp_nx   = start_grp_c;
        end
      end
      SEND: begin
        if (xfer_c) begin
          if (!last_xfer_c) begin
            idx_nx   = band_idx + BAND_W'(1);
            data_nx  = band_of(rd_data_c, idx_nx);
            first_nx = 1'b0;
            last_nx  = (idx_nx == LAST);
          end else if ((occ == 2'd2) || accept_c) begin
            idx_nx   = '0;
            data_nx  = band_of(start_data_c, '0);
            first_nx = 1'b1;
            last_nx  = 1'b0;
            grp_nx   = start_grp_c;
          end else begin
            state_nx = IDLE;
            do_en_nx = 1'b0;
            first_nx = 1'b0;
            last_nx  = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mel_frame_serializer.sv
// Directed bench for mel_frame_serializer; honours MEL_SER_CLAMP_NEG_EN for the negative-band case.
module tb_mel_frame_serializer;

  localparam int unsigned I_BW = 14;
  localparam int unsigned FW   = I_BW * 64;

  logic          clk;
  logic          rst;
  logic          di_en;
  logic [FW-1:0] data_i;
  logic [6:0]    in_group_num;
  logic          o_ready;
  logic          do_en;
  logic [I_BW-1:0] data_o;
  logic [5:0]    band_idx;
  logic          is_first_out;
  logic          is_last_out;
  logic [6:0]    out_group_num;
  logic          overflow;

  int n_chk;
  int n_err;

  mel_frame_serializer #(
    .I_BW    (I_BW),
    .N_BANDS (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .di_en         (di_en),
    .data_i        (data_i),
    .in_group_num  (in_group_num),
    .o_ready       (o_ready),
    .do_en         (do_en),
    .data_o        (data_o),
    .band_idx      (band_idx),
    .is_first_out  (is_first_out),
    .is_last_out   (is_last_out),
    .out_group_num (out_group_num),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dv(input int v);
    logic [I_BW-1:0] t;
    t = I_BW'(v);
    return 32'(t);
  endfunction

  function automatic logic [FW-1:0] mk_frame(input int base);
    logic [FW-1:0] f;
    f = '0;
    for (int b = 0; b < 64; b++) f[(63-b)*I_BW +: I_BW] = I_BW'(base + b);
    return f;
  endfunction

  task automatic chk_band(input string tag, input int idx, input int val,
                          input logic first, input logic last, input int grp);
    chk({tag, "_en"},    32'(do_en),         32'd1);
    chk({tag, "_idx"},   32'(band_idx),      32'(idx));
    chk({tag, "_data"},  32'(data_o),        dv(val));
    chk({tag, "_first"}, 32'(is_first_out),  32'(first));
    chk({tag, "_last"},  32'(is_last_out),   32'(last));
    chk({tag, "_grp"},   32'(out_group_num), 32'(grp));
  endtask

  task automatic send(input logic [FW-1:0] f, input int grp);
    di_en        = 1'b1;
    data_i       = f;
    in_group_num = 7'(grp);
    step();
    di_en        = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    32'(do_en),         32'd0);
    chk({tag, "_data"},  32'(data_o),        32'd0);
    chk({tag, "_idx"},   32'(band_idx),      32'd0);
    chk({tag, "_first"}, 32'(is_first_out),  32'd0);
    chk({tag, "_last"},  32'(is_last_out),   32'd0);
    chk({tag, "_grp"},   32'(out_group_num), 32'd0);
    chk({tag, "_ovf"},   32'(overflow),      32'd0);
  endtask

  initial begin
    logic [FW-1:0]   f;
    int              n_en, n_xf;
    logic            phase, stalled;
    logic [I_BW-1:0] p_data;
    logic [5:0]      p_idx;
    logic            p_first, p_last;
    logic [6:0]      p_grp;
    int              exp_neg;

    n_chk = 0;
    n_err = 0;
    rst = 1'b0; di_en = 1'b0; data_i = '0; in_group_num = '0; o_ready = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();

    // Single frame, bands 1..64, group 5, downstream always ready.
    o_ready = 1'b1;
    send(mk_frame(1), 5);
    for (int b = 0; b < 64; b++) begin
      chk_band("t1", b, b + 1, b == 0, b == 63, 5);
      step();
    end
    chk("t1_idle", 32'(do_en), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);

    // Ready toggling 1,0,1,0... starting on the first valid cycle.
    o_ready = 1'b0;
    send(mk_frame(100), 7);
    chk("t2_lat", 32'(do_en), 32'd1);
    n_en = 0; n_xf = 0; phase = 1'b1; stalled = 1'b0;
    p_data = '0; p_idx = '0; p_first = 1'b0; p_last = 1'b0; p_grp = '0;
    for (int c = 0; c < 300 && n_xf < 64; c++) begin
      if (do_en) begin
        n_en++;
        chk("t2_idx", 32'(band_idx), 32'(n_xf));
        chk("t2_data", 32'(data_o), dv(100 + n_xf));
        if (stalled) begin
          chk("t2_hold_data", 32'(data_o), 32'(p_data));
          chk("t2_hold_idx", 32'(band_idx), 32'(p_idx));
          chk("t2_hold_flags", 32'({is_first_out, is_last_out}), 32'({p_first, p_last}));
          chk("t2_hold_grp", 32'(out_group_num), 32'(p_grp));
        end
        p_data = data_o; p_idx = band_idx; p_first = is_first_out;
        p_last = is_last_out; p_grp = out_group_num;
        o_ready = phase;
        if (phase) n_xf++;
        stalled = !phase;
        phase = !phase;
      end
      step();
    end
    chk("t2_xfers", 32'(n_xf), 32'd64);
    chk("t2_en_cycles", 32'(n_en), 32'd127);
    chk("t2_idle", 32'(do_en), 32'd0);

    // Three back-to-back frames while stalled: third is dropped.
    o_ready = 1'b0;
    send(mk_frame(10), 1);
    send(mk_frame(200), 2);
    send(mk_frame(500), 3);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk_band("t3_hold", 0, 10, 1'b1, 1'b0, 1);
    o_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      chk_band("t3_stream", i % 64, (i < 64) ? 10 + i : 200 + (i - 64),
               (i % 64) == 0, (i % 64) == 63, (i < 64) ? 1 : 2);
      step();
    end
    chk("t3_idle", 32'(do_en), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b0;
    step();
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    rst = 1'b1;
    step();

    // Full buffer, new frame arrives on the band-63 transfer cycle.
    o_ready = 1'b0;
    send(mk_frame(1000), 10);
    send(mk_frame(2000), 11);
    chk_band("t4_a0", 0, 1000, 1'b1, 1'b0, 10);
    o_ready = 1'b1;
    for (int i = 0; i < 63; i++) step();
    chk_band("t4_a63", 63, 1063, 1'b0, 1'b1, 10);
    send(mk_frame(3000), 12);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk_band("t4_b0", 0, 2000, 1'b1, 1'b0, 11);
    for (int i = 0; i < 63; i++) step();
    chk_band("t4_b63", 63, 2063, 1'b0, 1'b1, 11);
    step();
    chk_band("t4_c0", 0, 3000, 1'b1, 1'b0, 12);
    for (int i = 0; i < 63; i++) step();
    chk_band("t4_c63", 63, 3063, 1'b0, 1'b1, 12);
    step();
    chk("t4_idle", 32'(do_en), 32'd0);
    chk("t4_ovf_end", 32'(overflow), 32'd0);

    // Negative band value.
    f = mk_frame(0);
    f[(63-10)*I_BW +: I_BW] = I_BW'(-5);
`ifdef MEL_SER_CLAMP_NEG_EN
    exp_neg = 0;
`else
    exp_neg = -5;
`endif
    send(f, 20);
    for (int i = 0; i < 9; i++) step();
    chk_band("t5_b9", 9, 9, 1'b0, 1'b0, 20);
    step();
    chk_band("t5_neg", 10, exp_neg, 1'b0, 1'b0, 20);
    step();
    chk_band("t5_b11", 11, 11, 1'b0, 1'b0, 20);
    for (int i = 0; i < 53; i++) step();
    chk("t5_idle", 32'(do_en), 32'd0);

    // Reset mid-frame at band 30, with a frame offered during reset.
    send(mk_frame(40), 30);
    for (int i = 0; i < 30; i++) step();
    chk_band("t6_b30", 30, 70, 1'b0, 1'b0, 30);
    rst = 1'b0;
    di_en = 1'b1; data_i = mk_frame(7); in_group_num = 7'd9;
    step();
    chk_all_zero("t6_rst");
    rst = 1'b1;
    di_en = 1'b0;
    step();
    chk("t6_ignored", 32'(do_en), 32'd0);
    send(mk_frame(50), 31);
    chk_band("t6_new", 0, 50, 1'b1, 1'b0, 31);
    chk("t6_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 63; i++) step();
    chk_band("t6_b63", 63, 113, 1'b0, 1'b1, 31);
    step();
    chk("t6_idle", 32'(do_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mel_frame_serializer.md
MEL_FRAME_SERIALIZER -- requirements
Module: mel_frame_serializer

Interface
REQ-001 SHALL have parameter I_BW, default 14, meaning signed width of one mel band value.
REQ-002 SHALL have parameter N_BANDS, default 64, meaning bands per packed frame; only 64 is supported.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port di_en  input  1  one-cycle strobe: packed frame present on data_i.
REQ-006 SHALL have port data_i  input  I_BW*64  packed signed bands; band b at bits [(63-b)*I_BW +: I_BW], so band 0 is in the MSBs.
REQ-007 SHALL have port in_group_num  input  7  frame number 0-88, sampled with di_en.
REQ-008 SHALL have port o_ready  input  1  downstream accepts the current band.
REQ-009 SHALL have port do_en  output  1  data_o/band_idx/flags valid.
REQ-010 SHALL have port data_o  output  I_BW  signed band value.
REQ-011 SHALL have port band_idx  output  6  band index 0-63.
REQ-012 SHALL have port is_first_out  output  1  high with band 0.
REQ-013 SHALL have port is_last_out  output  1  high with band 63.
REQ-014 SHALL have port out_group_num  output  7  frame number of the band being presented.
REQ-015 SHALL have port overflow  output  1  sticky: a frame was dropped.

Function
REQ-016 SHALL store frames in a two-slot ping-pong buffer, each slot holding data_i plus in_group_num, with write pointer, read pointer and a 2-bit occupancy count.
REQ-017 SHALL capture a frame on di_en when occupancy < 2, or when occupancy == 2 and band 63 transfers in the same cycle, which frees a slot.
REQ-018 SHALL otherwise drop the frame, leave buffer contents unchanged and set overflow to 1 until reset.
REQ-019 SHALL use FSM states IDLE and SEND: IDLE->SEND when occupancy becomes nonzero; SEND->IDLE after band 63 transfers with no other frame stored; SEND->SEND (band 0 of the next slot) when another frame is stored.
REQ-020 SHALL assert do_en on the cycle after the capturing edge when IDLE, a latency of 1 cycle.
REQ-021 SHALL complete a transfer on any cycle with do_en && o_ready, then advance band_idx; data_o, band_idx, the flags and out_group_num SHALL hold stable while do_en && !o_ready.
REQ-022 SHALL sustain one band per cycle with o_ready held high, including back-to-back frames with no gap between band 63 and the next band 0.
REQ-023 SHALL take data_o as the slot's bits [(63-band_idx)*I_BW +: I_BW], unmodified except as stated in REQ-027.
REQ-024 SHALL ignore di_en while rst is low.

Reset
REQ-025 SHALL set, on a clk edge with rst low: do_en=0, data_o=0, band_idx=0, is_first_out=0, is_last_out=0, out_group_num=0, overflow=0, occupancy=0, both pointers=0, FSM=IDLE.
REQ-026 SHALL, on reset in the middle of a frame, abandon that frame; the first frame after reset starts at band 0.

Configuration
REQ-027 SHALL, when macro MEL_SER_CLAMP_NEG_EN is defined, output 0 for any negative band value; these arise from accumulator wrap upstream.
REQ-028 SHALL, when MEL_SER_CLAMP_NEG_EN is undefined, pass the band value through bit-exact with sign preserved.

Structure
REQ-029 SHALL place N_BANDS, the band index width (6), the group number width (7) and the FSM state encoding in shared package mel_pkg.
REQ-030 SHALL implement the two-slot storage as sub-module mel_frame_buf, which holds the slots and pointers and provides a write port and a read-select output; the parent holds the FSM, band counter and output registers.

Verification
REQ-031 SHALL cover: one frame with band b = b+1, group 5, o_ready=1 -> do_en 1 cycle after di_en, 64 consecutive bands with values 1..64, first/last flags on bands 0 and 63, out_group_num=5.
REQ-032 SHALL cover: o_ready toggling 1010... -> exactly 64 transfers, outputs stable on stalled cycles, total 127 cycles of do_en.
REQ-033 SHALL cover: three frames (groups 1,2,3) on consecutive cycles with o_ready=0 -> groups 1 and 2 kept, 3 dropped, overflow=1; after o_ready=1, 128 bands stream gap-free.
REQ-034 SHALL cover: buffer full with di_en in the same cycle as the band-63 transfer -> new frame accepted, overflow stays 0.
REQ-035 SHALL cover: band 10 = -5 -> data_o=0 with MEL_SER_CLAMP_NEG_EN defined; data_o=-5 without it.
REQ-036 SHALL cover: rst low at band 30 for 1 cycle -> all outputs 0; the next frame starts at band 0 with overflow 0.
